// File: rtl/vpg_pkg.sv
// Shared VPG definitions: mode index encodings and default mode-table size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vpg_pkg;

    localparam int VPG_MODE_W    = 4;
    localparam int VPG_NUM_MODES = 10;

    // Timing-mode indices as understood by the VPG timing core and HDMI TX.
    typedef enum logic [VPG_MODE_W-1:0] {
        VGA_640x480p60    = 4'd0,
        SVGA_800x600p60   = 4'd1,
        XGA_1024x768p60   = 4'd2,
        HD_1280x720p60    = 4'd3,
        WXGA_1280x800p60  = 4'd4,
        SXGA_1280x1024p60 = 4'd5,
        WXGAP_1440x900p60 = 4'd6,
        HDP_1600x900p60   = 4'd7,
        UXGA_1600x1200p60 = 4'd8,
        FHD_1920x1080p60  = 4'd9
    } vpg_mode_e;

endpackage

// File: rtl/vpg_mode_sel_if.sv
// Control-side bundle of the mode selector: buttons, direct load, mask, mode outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all requests are fire-and-forget, sampled on clk_en ticks.
interface vpg_mode_sel_if
    import vpg_pkg::*;
#(
    parameter int MODE_W    = VPG_MODE_W,
    parameter int NUM_MODES = VPG_NUM_MODES
);

    logic                 btn_next;
    logic                 btn_prev;
    logic                 load_valid;
    logic [MODE_W-1:0]    load_mode;
    logic [NUM_MODES-1:0] mode_mask;
    logic [MODE_W-1:0]    vpg_mode;
    logic                 vpg_mode_change;
    logic                 load_err;

    // Board buttons / control logic side.
    modport master (
        output btn_next,
        output btn_prev,
        output load_valid,
        output load_mode,
        output mode_mask,
        input  vpg_mode,
        input  vpg_mode_change,
        input  load_err
    );

    // Mode selector side.
    modport slave (
        input  btn_next,
        input  btn_prev,
        input  load_valid,
        input  load_mode,
        input  mode_mask,
        output vpg_mode,
        output vpg_mode_change,
        output load_err
    );

endinterface

// File: rtl/vpg_debounce.sv
// Button debouncer: accepts a raw level after DEBOUNCE_CYC stable ticks, flags 0->1 edges.
// Latency: stable updates on tick DEBOUNCE_CYC of a steady level; rise is a registered 1-tick pulse.
// Backpressure: none; state only advances on clk_en ticks and holds otherwise.
module vpg_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_en,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreeing ticks; commit the raw level once the count
    // completes. The stable level starts high so a button held through reset
    // must be released and pressed again before it produces an event. The raw
    // input is expected to arrive through the board's pad synchronizer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b1;
            rise   <= 1'b0;
        end else if (clk_en) begin
            if (raw != stable) begin
                if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    cnt    <= '0;
                    stable <= raw;
                    rise   <= raw;
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    rise <= 1'b0;
                end
            end else begin
                cnt  <= '0;
                rise <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vpg_mode_sel.sv
// Video-mode selector: steps/loads the active VPG mode through the enabled set, strobes changes.
// Latency: load 1 tick; button DEBOUNCE_CYC+1 ticks; auto step on tick STARTUP_DELAY.
// Backpressure: none; coincident lower-priority events are discarded, clk_en=0 freezes all state.
module vpg_mode_sel
    import vpg_pkg::*;
#(
    parameter int MODE_W        = VPG_MODE_W,
    parameter int NUM_MODES     = VPG_NUM_MODES,
    parameter int RESET_MODE    = FHD_1920x1080p60,
    parameter int DEBOUNCE_CYC  = 16,
    parameter int AUTO_INIT     = 1,
    parameter int STARTUP_DELAY = 9,
    parameter int CHANGE_HOLD   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk_en,
    vpg_mode_sel_if.slave bus
);

    localparam int EXT_W  = 2 ** MODE_W;
    localparam int IDX_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int ST_W   = $clog2(STARTUP_DELAY + 1);
    localparam int HOLD_W = $clog2(CHANGE_HOLD + 1);

    // First enabled index after cur in the requested direction, wrapping
    // explicitly at NUM_MODES. Returns cur when nothing else is enabled,
    // which the caller sees as "no change".
    function automatic logic [MODE_W-1:0] step_search(
        input logic [MODE_W-1:0]    cur,
        input logic [NUM_MODES-1:0] mask,
        input logic                 fwd
    );
        logic [MODE_W-1:0] res;
        logic              found;
        int                idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < NUM_MODES; k++) begin
            if (fwd) begin
                idx = int'(cur) + k;
                if (idx >= NUM_MODES) idx = idx - NUM_MODES;
            end else begin
                idx = int'(cur) - k;
                if (idx < 0) idx = idx + NUM_MODES;
            end
            if (!found && mask[IDX_W'(idx)]) begin
                res   = MODE_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    logic                 next_stable;
    logic                 next_rise;
    logic                 prev_stable;
    logic                 prev_rise;
    logic                 unused_stable;

    logic [MODE_W-1:0]    mode_q;
    logic [MODE_W-1:0]    mode_d;
    logic [EXT_W-1:0]     mask_ext;
    logic                 load_ok;
    logic                 auto_fire;
    logic                 fwd_req;
    logic                 bwd_req;
    logic                 load_err_q;
    logic                 change_q;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [ST_W-1:0]      start_cnt;

    vpg_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db_next (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .raw     (bus.btn_next),
        .stable  (next_stable),
        .rise    (next_rise)
    );

    vpg_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db_prev (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .raw     (bus.btn_prev),
        .stable  (prev_stable),
        .rise    (prev_rise)
    );

    // Only the press edges drive stepping; the debounced levels are not needed here.
    assign unused_stable = next_stable ^ prev_stable;

    // Startup tick counter: runs from reset release and saturates after the auto step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_cnt <= '0;
        end else if (clk_en && (start_cnt < ST_W'(STARTUP_DELAY))) begin
            start_cnt <= start_cnt + ST_W'(1);
        end
    end

    // Arbitrate load > forward (press or auto) > backward and pick the next mode.
    always_comb begin
        mask_ext  = EXT_W'(bus.mode_mask);
        load_ok   = mask_ext[bus.load_mode];
        auto_fire = (AUTO_INIT != 0) && clk_en
                    && (start_cnt == ST_W'(STARTUP_DELAY - 1));
        // Opposing presses cancel unless the auto step forces a forward move.
        fwd_req   = auto_fire || (next_rise && !prev_rise);
        bwd_req   = !fwd_req && prev_rise && !next_rise;
        mode_d    = mode_q;
        if (bus.load_valid) begin
            if (load_ok) mode_d = bus.load_mode;
        end else if (fwd_req) begin
            mode_d = step_search(mode_q, bus.mode_mask, 1'b1);
        end else if (bwd_req) begin
            mode_d = step_search(mode_q, bus.mode_mask, 1'b0);
        end
    end

    // Mode register and one-tick rejected-load flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q     <= MODE_W'(RESET_MODE);
            load_err_q <= 1'b0;
        end else if (clk_en) begin
            mode_q     <= mode_d;
            load_err_q <= bus.load_valid && !load_ok;
        end
    end

    // Change strobe: any real mode change (re)loads the hold window so that
    // back-to-back changes merge into one continuous pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            change_q <= 1'b0;
        end else if (clk_en) begin
            if (mode_d != mode_q) begin
                hold_cnt <= HOLD_W'(CHANGE_HOLD - 1);
                change_q <= 1'b1;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
                change_q <= 1'b1;
            end else begin
                change_q <= 1'b0;
            end
        end
    end

    assign bus.vpg_mode        = mode_q;
    assign bus.vpg_mode_change = change_q;
    assign bus.load_err        = load_err_q;

endmodule

// File: tb/tb_vpg_mode_sel.sv
// Self-checking bench for vpg_mode_sel with default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_vpg_mode_sel;
    import vpg_pkg::*;

    logic clk;
    logic reset_n;
    logic clk_en;

    vpg_mode_sel_if #(.MODE_W(4), .NUM_MODES(10)) sel ();

    vpg_mode_sel #(
        .MODE_W        (4),
        .NUM_MODES     (10),
        .RESET_MODE    (9),
        .DEBOUNCE_CYC  (16),
        .AUTO_INIT     (1),
        .STARTUP_DELAY (9),
        .CHANGE_HOLD   (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .bus     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    mode;
        int    chg;
        int    err;
    } exp_t;

    typedef struct {
        logic       lv;
        logic [3:0] lm;
        logic [9:0] mask;
        int         emode;
        int         echg;
        int         eerr;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[13];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Push the expectation for the coming tick, clock once, then pop and compare.
    task automatic step_chk(input string name, input int emode, input int echg, input int eerr);
        exp_t e;
        e.name = name;
        e.mode = emode;
        e.chg  = echg;
        e.err  = eerr;
        sb_q.push_back(e);
        tick();
        e = sb_q.pop_front();
        chk({e.name, "/mode"}, int'(sel.vpg_mode), e.mode);
        chk({e.name, "/chg"},  int'(sel.vpg_mode_change), e.chg);
        chk({e.name, "/err"},  int'(sel.load_err), e.err);
    endtask

    initial begin
        // Load-path vectors, applied one per tick starting from mode 9, idle strobe.
        vecs[0]  = '{1'b1, 4'd12, 10'h3FF, 9, 0, 1};
        vecs[1]  = '{1'b0, 4'd0,  10'h3FF, 9, 0, 0};
        vecs[2]  = '{1'b1, 4'd3,  10'h3F7, 9, 0, 1};
        vecs[3]  = '{1'b1, 4'd9,  10'h3FF, 9, 0, 0};
        vecs[4]  = '{1'b1, 4'd15, 10'h3FF, 9, 0, 1};
        vecs[5]  = '{1'b1, 4'd5,  10'h3FF, 5, 1, 0};
        vecs[6]  = '{1'b0, 4'd0,  10'h3FF, 5, 1, 0};
        vecs[7]  = '{1'b1, 4'd10, 10'h3FF, 5, 1, 1};
        vecs[8]  = '{1'b0, 4'd0,  10'h3FF, 5, 1, 0};
        vecs[9]  = '{1'b0, 4'd0,  10'h3FF, 5, 0, 0};
        vecs[10] = '{1'b0, 4'd0,  10'h3DF, 5, 0, 0};
        vecs[11] = '{1'b1, 4'd5,  10'h3DF, 5, 0, 1};
        vecs[12] = '{1'b0, 4'd0,  10'h3DF, 5, 0, 0};

        clk_en         = 1'b1;
        reset_n        = 1'b0;
        sel.btn_next   = 1'b0;
        sel.btn_prev   = 1'b0;
        sel.load_valid = 1'b0;
        sel.load_mode  = 4'd0;
        sel.mode_mask  = 10'h3FF;

        // Reset state.
        idle(2);
        chk("rst/mode", int'(sel.vpg_mode), 9);
        chk("rst/chg",  int'(sel.vpg_mode_change), 0);
        chk("rst/err",  int'(sel.load_err), 0);

        // Auto step on tick 9 wraps 9 -> 0 with a 4-tick strobe.
        reset_n = 1'b1;
        for (int t = 1; t <= 14; t++)
            step_chk("auto", (t >= 9) ? 0 : 9, (t >= 9 && t <= 12) ? 1 : 0, 0);
        idle(6);

        // Held next press: mode moves on tick 17 after the press.
        sel.btn_next = 1'b1;
        for (int t = 1; t <= 20; t++)
            step_chk("next_hold", (t >= 17) ? 1 : 0, (t >= 17) ? 1 : 0, 0);
        sel.btn_next = 1'b0;
        idle(20);

        // 8-tick glitch is filtered out.
        sel.btn_next = 1'b1;
        idle(8);
        sel.btn_next = 1'b0;
        for (int t = 1; t <= 24; t++) step_chk("glitch", 1, 0, 0);

        // Sparse mask {0,2,9}: prev from 2 -> 0, then wraps to 9.
        sel.mode_mask  = 10'b10_0000_0101;
        sel.load_valid = 1'b1;
        sel.load_mode  = 4'd2;
        step_chk("load2", 2, 1, 0);
        sel.load_valid = 1'b0;
        idle(6);
        sel.btn_prev = 1'b1;
        for (int t = 1; t <= 18; t++)
            step_chk("prev_skip", (t >= 17) ? 0 : 2, (t >= 17) ? 1 : 0, 0);
        sel.btn_prev = 1'b0;
        idle(20);
        sel.btn_prev = 1'b1;
        for (int t = 1; t <= 18; t++)
            step_chk("prev_wrap", (t >= 17) ? 9 : 0, (t >= 17) ? 1 : 0, 0);
        sel.btn_prev = 1'b0;
        idle(20);

        // Table-driven load vectors.
        for (int i = 0; i < 13; i++) begin
            sel.load_valid = vecs[i].lv;
            sel.load_mode  = vecs[i].lm;
            sel.mode_mask  = vecs[i].mask;
            step_chk($sformatf("vec%0d", i), vecs[i].emode, vecs[i].echg, vecs[i].eerr);
        end
        sel.load_valid = 1'b0;
        sel.mode_mask  = 10'h3FF;

        // Load coincident with a next press: load wins, press discarded.
        sel.btn_next = 1'b1;
        for (int t = 1; t <= 16; t++) step_chk("ldnext_wait", 5, 0, 0);
        sel.load_valid = 1'b1;
        sel.load_mode  = 4'd3;
        step_chk("ldnext", 3, 1, 0);
        sel.load_valid = 1'b0;
        for (int t = 1; t <= 3; t++) step_chk("ldnext_disc", 3, 1, 0);
        sel.btn_next = 1'b0;
        idle(20);

        // Retrigger 2 ticks into the hold: one 6-tick strobe.
        sel.load_valid = 1'b1;
        sel.load_mode  = 4'd1;
        step_chk("retrig", 1, 1, 0);
        sel.load_valid = 1'b0;
        step_chk("retrig", 1, 1, 0);
        sel.load_valid = 1'b1;
        sel.load_mode  = 4'd2;
        step_chk("retrig", 2, 1, 0);
        sel.load_valid = 1'b0;
        for (int t = 1; t <= 3; t++) step_chk("retrig", 2, 1, 0);
        step_chk("retrig_end", 2, 0, 0);

        // Only the current mode enabled: a press is a no-op with no strobe.
        sel.mode_mask = 10'b00_0000_0100;
        sel.btn_next  = 1'b1;
        for (int t = 1; t <= 20; t++) step_chk("single", 2, 0, 0);
        sel.btn_next = 1'b0;
        idle(20);

        // Reset mid-strobe aborts it; next held through reset gives no step.
        sel.mode_mask  = 10'h3FF;
        sel.load_valid = 1'b1;
        sel.load_mode  = 4'd4;
        step_chk("pre_rst", 4, 1, 0);
        sel.load_valid = 1'b0;
        sel.btn_next   = 1'b1;
        reset_n        = 1'b0;
        tick();
        chk("midrst/mode", int'(sel.vpg_mode), 9);
        chk("midrst/chg",  int'(sel.vpg_mode_change), 0);
        reset_n = 1'b1;
        for (int t = 1; t <= 30; t++)
            step_chk("held_rst", (t >= 9) ? 0 : 9, (t >= 9 && t <= 12) ? 1 : 0, 0);
        sel.btn_next = 1'b0;
        for (int t = 1; t <= 20; t++) step_chk("held_rel", 0, 0, 0);

        // clk_en low mid-debounce freezes the counter and ignores loads.
        sel.btn_next = 1'b1;
        for (int t = 1; t <= 10; t++) step_chk("frz_pre", 0, 0, 0);
        clk_en         = 1'b0;
        sel.load_valid = 1'b1;
        sel.load_mode  = 4'd5;
        for (int c = 1; c <= 50; c++) step_chk("frz", 0, 0, 0);
        sel.load_valid = 1'b0;
        clk_en         = 1'b1;
        for (int t = 1; t <= 7; t++)
            step_chk("frz_post", (t >= 7) ? 1 : 0, (t >= 7) ? 1 : 0, 0);
        sel.btn_next = 1'b0;
        idle(20);

        // load_err holds while clk_en is low, clears on the next real tick.
        sel.load_valid = 1'b1;
        sel.load_mode  = 4'd12;
        step_chk("err_set", 1, 0, 1);
        sel.load_valid = 1'b0;
        clk_en         = 1'b0;
        for (int c = 1; c <= 5; c++) step_chk("err_hold", 1, 0, 1);
        clk_en = 1'b1;
        step_chk("err_clr", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vpg_mode_sel.md
# vpg_mode_sel

Parametrised video-mode selector for the video pattern generator (VPG). It holds the active timing-mode index and steps forward or backward through a configurable set of enabled modes on debounced push-button presses, direct loads or a one-shot power-up advance. Each mode update raises a stretched `vpg_mode_change` pulse that the timing generator and HDMI transmitter use to re-initialise. It sits between the board buttons / control logic and the VPG timing core.

## Interface

- `MODE_W`, 4: width of the mode index.
- `NUM_MODES`, 10: number of valid modes, 0..NUM_MODES-1; must satisfy 2 ≤ NUM_MODES ≤ 2^MODE_W.
- `RESET_MODE`, 9: mode after reset (FHD_1920x1080p60); must be < NUM_MODES.
- `DEBOUNCE_CYC`, 16: clk_en ticks a raw button level must be stable to be accepted; ≥ 1.
- `AUTO_INIT`, 1: 1 enables the one-shot automatic forward step after reset.
- `STARTUP_DELAY`, 9: clk_en tick, counted from reset release, on which the automatic step occurs; ≥ 1.
- `CHANGE_HOLD`, 4: clk_en ticks that `vpg_mode_change` stays high per update; ≥ 1.

Ports:

- `clk` in 1: single clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `clk_en` in 1: tick enable; all state advances only on edges where `clk_en`=1.
- `btn_next` in 1: raw, active-high, asynchronous to logic; step forward.
- `btn_prev` in 1: raw, active-high; step backward.
- `load_valid` in 1: direct-load request, sampled on ticks.
- `load_mode` in MODE_W: mode to load.
- `mode_mask` in NUM_MODES: bit i = 1 means mode i is enabled.
- `vpg_mode` out MODE_W: current mode.
- `vpg_mode_change` out 1: stretched change strobe.
- `load_err` out 1: rejected-load flag.

## Operation

- **Reset** (reset_n=0 at a clk edge, regardless of clk_en):
  - vpg_mode=RESET_MODE, vpg_mode_change=0, load_err=0.
  - Debounced button levels are set to 1, so a button held through reset must be released and pressed again.
  - Debounce counters, hold counter and startup counter are cleared.
  - Reset mid-operation aborts any pending step or pulse.
- **Debounce** (per button): while raw ≠ stable level, the counter increments each tick; any tick with raw = stable clears it. When the counter reaches DEBOUNCE_CYC, the stable level takes the raw value and the counter clears. A press event is the stable level's 0→1 transition only.
- **Step search** (combinational):
  - next: the first enabled index after vpg_mode in ascending order, wrapping NUM_MODES-1→0.
  - prev: the first enabled index in descending order, wrapping 0→NUM_MODES-1.
  - If no enabled index other than the current one exists, the step is a no-op: mode unchanged, no change pulse.
- **Event priority** per tick:
  1. load_valid.
  2. forward request: next press OR the auto step.
  3. prev press.
  - Next and prev presses on the same tick cancel each other (no-op), unless the auto step also fires, in which case a single forward step occurs.
- **Load**:
  - Accepted if load_mode < NUM_MODES and mode_mask[load_mode]=1: vpg_mode=load_mode.
  - Rejected otherwise: load_err=1 for that tick, mode unchanged.
  - Loading the current mode is accepted without a change pulse.
  - A load suppresses any coincident button or auto step; those events are discarded, not queued.
- **Auto step**: if AUTO_INIT=1, the startup counter counts ticks after reset. On tick STARTUP_DELAY it issues exactly one forward request, then saturates. The auto step uses the normal search and honours mode_mask.
- **Change strobe**: every actual change of vpg_mode loads the hold counter with CHANGE_HOLD, and vpg_mode_change=1 while the counter is nonzero. A new change during the hold reloads the counter (retrigger, no gap).
- **Mask**: a mask change that disables the current mode does not move vpg_mode; the next step searches from the current index. Mask is read only on ticks.
- Arithmetic: indices are MODE_W bits; wrap is explicit at NUM_MODES, never by natural overflow.

## Timing

- Registered outputs; no combinational input→output path.
- Raw press held from before tick 1: stable level rises on tick DEBOUNCE_CYC; vpg_mode updates and vpg_mode_change rises on tick DEBOUNCE_CYC+1.
- Load: vpg_mode or load_err updates on the same tick load_valid is sampled (1-tick latency).
- vpg_mode_change is high for exactly CHANGE_HOLD ticks starting with the update tick.
- load_err is high for one tick and clears on the next tick without a rejected load.
- clk_en=0: all registers hold, including the counters and load_err.

## Structure

- Package `vpg_pkg`: the mode index encodings (VGA_640x480p60=0 … FHD_1920x1080p60=9) and the default NUM_MODES, shared with the timing core.
- Sub-module `vpg_debounce` (parameter DEBOUNCE_CYC; ports clk, reset_n, clk_en, raw, stable, rise), instantiated once per button.
- Step search as a function or for-loop in the top module.

## Test plan

- Defaults, all modes enabled, buttons idle → vpg_mode=9 after reset; on tick 9 becomes 0 with vpg_mode_change high for 4 ticks.
- btn_next held 20 ticks from mode 0 → mode 1 on tick 17 from press; an 8-tick glitch → no change.
- mode_mask=10'b10_0000_0101, mode 2, btn_prev press → 0; press again → 9 (wrap, skip disabled).
- Load 12 → load_err for one tick, mode unchanged; load 3 with mask bit 3=0 → load_err; load 3 enabled, simultaneous next press → mode 3, next discarded.
- Second change 2 ticks into the hold → vpg_mode_change high continuously for 6 ticks total; only one mode enabled → button press gives no pulse.
- btn_next held through reset → no step after release of reset; clk_en low for 50 cycles mid-debounce → counter frozen, resumes after.
